// File: rtl/matrix_io_pkg.sv
// matrix_io_pkg
// Shared types and constants for the 3x3 matrix streaming controller and the
// matrix_mult engine it drives: FSM state enum, operand/result widths, stream
// lengths, and a helper that picks one output byte out of an 18-bit result.
package matrix_io_pkg;

  localparam int N             = 3;
  localparam int NUM_ELEMS     = N * N;
  localparam int NUM_IN_BYTES  = 18;
  localparam int NUM_OUT_BYTES = 27;
  localparam int ELEM_W        = 8;
  localparam int RES_W         = 18;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    SEND  = 2'd3
  } state_e;

  // part 0: bits [7:0], part 1: bits [15:8], part 2: zero-padded bits [17:16]
  function automatic logic [7:0] res_byte(input logic [RES_W-1:0] w,
                                          input logic [1:0]       part);
    case (part)
      2'd0:    res_byte = w[7:0];
      2'd1:    res_byte = w[15:8];
      default: res_byte = {6'b0, w[17:16]};
    endcase
  endfunction

endpackage

// File: rtl/matrix_mult.sv
// matrix_mult
// Sequential 3x3 multiplier C = A * B with 8-bit operands and 18-bit results.
// One result element is produced per clock after an enable pulse; done drops
// on the cycle after enable and rises again once all nine elements are written.
// Ports:
//   clk, reset (async active-low)
//   enable  in   start pulse; A/B must stay stable until done
//   A, B    in   9x8 row-major operands
//   C       out  9x18 row-major result, held until the next enable
//   done    out  high when idle with a valid (or reset) result
module matrix_mult
  import matrix_io_pkg::*;
(
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                enable,
  input  logic [NUM_ELEMS-1:0][ELEM_W-1:0]    A,
  input  logic [NUM_ELEMS-1:0][ELEM_W-1:0]    B,
  output logic [NUM_ELEMS-1:0][RES_W-1:0]     C,
  output logic                                done
);

  logic [1:0]                         row_q, col_q;
  logic                               run_q, done_q;
  logic [NUM_ELEMS-1:0][RES_W-1:0]    c_q;
  logic [RES_W-1:0]                   dot;

  always_comb begin
    dot = '0;
    for (int j = 0; j < N; j++) begin
      dot = dot + RES_W'(A[4'(row_q) * 4'(N) + 4'(j)]) *
                  RES_W'(B[4'(j) * 4'(N) + 4'(col_q)]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_q  <= '0;
      col_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b1;
      c_q    <= '0;
    end else if (enable) begin
      row_q  <= '0;
      col_q  <= '0;
      run_q  <= 1'b1;
      done_q <= 1'b0;
    end else if (run_q) begin
      c_q[4'(row_q) * 4'(N) + 4'(col_q)] <= dot;
      if (col_q == 2'(N - 1)) begin
        col_q <= '0;
        if (row_q == 2'(N - 1)) begin
          row_q  <= '0;
          run_q  <= 1'b0;
          done_q <= 1'b1;
        end else begin
          row_q <= row_q + 2'd1;
        end
      end else begin
        col_q <= col_q + 2'd1;
      end
    end
  end

  assign C    = c_q;
  assign done = done_q;

endmodule

// File: rtl/matrix_stream_ctrl.sv
// matrix_stream_ctrl
// Byte-stream front end for matrix_mult. Collects 18 operand bytes (A then B,
// row-major), pulses mm_enable, waits for a low-then-high mm_done, captures the
// nine 18-bit results and streams them out as 27 bytes (LSB, mid, top 2 bits).
// A WAIT that lasts DONE_TIMEOUT cycles sets the sticky err flag and returns
// to LOAD.
// Ports:
//   clk, reset (async active-low)
//   in_data/in_valid/in_ready      operand byte stream, accepted only in LOAD
//   out_data/out_valid/out_ready   result byte stream, driven only in SEND
//   mm_enable, mm_A, mm_B          start pulse and operands to matrix_mult
//   mm_C, mm_done                  result and completion from matrix_mult
//   busy                           high outside LOAD
//   err                            sticky timeout flag
//
// state | meaning
// LOAD  | accepting operand bytes 0..17
// START | one-cycle mm_enable pulse, operands frozen
// WAIT  | waiting for mm_done low-then-high, timeout counter running
// SEND  | emitting the 27 captured result bytes
module matrix_stream_ctrl
  import matrix_io_pkg::*;
#(
  parameter int DONE_TIMEOUT = 32
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [ELEM_W-1:0]                  in_data,
  input  logic                               in_valid,
  output logic                               in_ready,
  output logic [7:0]                         out_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               mm_enable,
  output logic [NUM_ELEMS-1:0][ELEM_W-1:0]   mm_A,
  output logic [NUM_ELEMS-1:0][ELEM_W-1:0]   mm_B,
  input  logic [NUM_ELEMS-1:0][RES_W-1:0]    mm_C,
  input  logic                               mm_done,
  output logic                               busy,
  output logic                               err
);

  localparam int TW = $clog2(DONE_TIMEOUT + 1);

  state_e                            state_q;
  logic [4:0]                        in_cnt_q;
  logic [TW-1:0]                     wait_cnt_q;
  logic [3:0]                        word_q;
  logic [1:0]                        part_q;
  logic                              seen_low_q;
  logic [NUM_ELEMS-1:0][ELEM_W-1:0]  a_q, b_q;
  logic [NUM_ELEMS-1:0][RES_W-1:0]   c_q;
  logic                              mm_enable_q;
  logic                              out_valid_q;
  logic [7:0]                        out_data_q;
  logic                              err_q;

  logic [3:0]                        word_d;
  logic [1:0]                        part_d;
  logic                              last_byte;

  always_comb begin
    part_d    = (part_q == 2'd2) ? 2'd0 : part_q + 2'd1;
    word_d    = (part_q == 2'd2) ? word_q + 4'd1 : word_q;
    last_byte = (word_q == 4'(NUM_ELEMS - 1)) && (part_q == 2'd2);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= LOAD;
      in_cnt_q    <= '0;
      wait_cnt_q  <= '0;
      word_q      <= '0;
      part_q      <= '0;
      seen_low_q  <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      mm_enable_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      mm_enable_q <= 1'b0;
      unique case (state_q)
        LOAD: begin
          if (in_valid) begin
            for (int k = 0; k < NUM_ELEMS; k++) begin
              if (in_cnt_q == 5'(k))             a_q[k] <= in_data;
              if (in_cnt_q == 5'(k + NUM_ELEMS)) b_q[k] <= in_data;
            end
            if (in_cnt_q == 5'(NUM_IN_BYTES - 1)) begin
              in_cnt_q    <= '0;
              seen_low_q  <= 1'b0;
              mm_enable_q <= 1'b1;
              state_q     <= START;
            end else begin
              in_cnt_q <= in_cnt_q + 5'd1;
            end
          end
        end
        START: begin
          if (!mm_done) seen_low_q <= 1'b1;
          wait_cnt_q <= '0;
          state_q    <= WAIT;
        end
        WAIT: begin
          // A done that was already high at START is a stale completion; only
          // a rising done after a sampled low belongs to this job.
          if (mm_done && seen_low_q) begin
            c_q         <= mm_C;
            out_data_q  <= res_byte(mm_C[0], 2'd0);
            out_valid_q <= 1'b1;
            word_q      <= '0;
            part_q      <= '0;
            state_q     <= SEND;
          end else begin
            if (!mm_done) seen_low_q <= 1'b1;
            if (wait_cnt_q == TW'(DONE_TIMEOUT - 1)) begin
              err_q    <= 1'b1;
              in_cnt_q <= '0;
              state_q  <= LOAD;
            end else begin
              wait_cnt_q <= wait_cnt_q + 1'b1;
            end
          end
        end
        SEND: begin
          if (out_ready) begin
            if (last_byte) begin
              out_valid_q <= 1'b0;
              out_data_q  <= '0;
              word_q      <= '0;
              part_q      <= '0;
              in_cnt_q    <= '0;
              state_q     <= LOAD;
            end else begin
              word_q     <= word_d;
              part_q     <= part_d;
              out_data_q <= res_byte(c_q[word_d], part_d);
            end
          end
        end
      endcase
    end
  end

  assign in_ready  = (state_q == LOAD);
  assign busy      = (state_q != LOAD);
  assign mm_enable = mm_enable_q;
  assign mm_A      = a_q;
  assign mm_B      = b_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign err       = err_q;

endmodule

// File: tb/tb_matrix_stream_ctrl.sv
module tb_matrix_stream_ctrl;

  localparam int TMO = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        out_data;
  logic              out_valid;
  logic              out_ready;
  logic              mm_enable;
  logic [8:0][7:0]   mm_A, mm_B;
  logic [8:0][17:0]  mm_C;
  logic              mm_done_raw;
  logic              mm_done;
  logic              busy;
  logic              err;
  logic              force_low;

  int n_vec = 0;
  int n_err = 0;
  int en_cnt = 0;

  logic [7:0] ld_a[9];
  logic [7:0] ld_b[9];
  int         exp_w[9];
  logic [7:0] exp_b[27];

  always #5 clk = ~clk;

  assign mm_done = force_low ? 1'b0 : mm_done_raw;

  matrix_stream_ctrl #(.DONE_TIMEOUT(TMO)) dut (
    .clk       (clk),
    .reset     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .mm_enable (mm_enable),
    .mm_A      (mm_A),
    .mm_B      (mm_B),
    .mm_C      (mm_C),
    .mm_done   (mm_done),
    .busy      (busy),
    .err       (err)
  );

  matrix_mult u_mm (
    .clk    (clk),
    .reset  (rst_n),
    .enable (mm_enable),
    .A      (mm_A),
    .B      (mm_B),
    .C      (mm_C),
    .done   (mm_done_raw)
  );

  always @(negedge clk) if (mm_enable) en_cnt++;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [71:0] pack9(input logic [7:0] v[9]);
    logic [71:0] r = '0;
    for (int k = 0; k < 9; k++) r[k*8 +: 8] = v[k];
    return r;
  endfunction

  // Reference: plain integer matrix product from the loaded operands.
  task automatic model_words();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        int s = 0;
        for (int j = 0; j < 3; j++) s += int'(ld_a[r*3+j]) * int'(ld_b[j*3+c]);
        exp_w[r*3+c] = s;
      end
  endtask

  task automatic words_to_bytes();
    for (int i = 0; i < 9; i++) begin
      exp_b[i*3]   = 8'(exp_w[i] & 255);
      exp_b[i*3+1] = 8'((exp_w[i] >> 8) & 255);
      exp_b[i*3+2] = 8'((exp_w[i] >> 16) & 3);
    end
  endtask

  task automatic rand_operands();
    for (int k = 0; k < 9; k++) begin
      ld_a[k] = 8'($urandom_range(255));
      ld_b[k] = 8'($urandom_range(255));
    end
  endtask

  task automatic load_all(input int nbytes, input bit gaps, input bit hold);
    int k = 0;
    int guard = 0;
    while (k < nbytes && guard < 4000) begin
      @(negedge clk);
      guard++;
      if (gaps && $urandom_range(3) == 0) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom_range(255));
      end else begin
        in_valid = 1'b1;
        in_data  = (k < 9) ? ld_a[k] : ld_b[k-9];
      end
      if (in_valid && in_ready) k++;
    end
    if (k < nbytes) check_val("load_timeout", 0, 1);
    if (nbytes == 18) begin
      @(negedge clk);
      in_valid = hold;
      in_data  = 8'hA5;
      check_val("start_enable", mm_enable, 1);
      check_val("start_in_ready", in_ready, 0);
      check_val("start_busy", busy, 1);
      check_val("mm_A", mm_A, pack9(ld_a));
      check_val("mm_B", mm_B, pack9(ld_b));
    end
  endtask

  task automatic recv_all(input int stall_at, input int stall_len, input bit rnd_ready);
    int idx = 0;
    int guard = 0;
    int stall = 0;
    logic [7:0] prev = '0;
    bit prev_held = 0;
    while (idx < 27 && guard < 3000) begin
      @(negedge clk);
      guard++;
      if (prev_held) begin
        check_val("hold_data", out_data, prev);
        check_val("hold_valid", out_valid, 1);
      end
      prev_held = 0;
      if (out_valid) begin
        check_val("send_in_ready", in_ready, 0);
        if (idx == stall_at && stall < stall_len) begin
          out_ready = 1'b0;
          stall++;
        end else begin
          out_ready = rnd_ready ? ($urandom_range(2) != 0) : 1'b1;
        end
        if (out_ready) begin
          check_val($sformatf("byte%0d", idx), out_data, exp_b[idx]);
          idx++;
        end else begin
          prev = out_data;
          prev_held = 1;
        end
      end else begin
        out_ready = 1'($urandom_range(1));
      end
    end
    if (idx < 27) check_val("recv_timeout", idx, 27);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check_val("end_valid", out_valid, 0);
    check_val("end_in_ready", in_ready, 1);
    check_val("mm_A_stable", mm_A, pack9(ld_a));
  endtask

  task automatic run_compute(input bit gaps, input int stall_at, input int stall_len,
                             input bit rnd_ready, input bit hold);
    int e0 = en_cnt;
    load_all(18, gaps, hold);
    recv_all(stall_at, stall_len, rnd_ready);
    check_val("enable_pulses", en_cnt - e0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    force_low = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h77;
    rst_n     = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_in_ready", in_ready, 1);
    check_val("rst_busy", busy, 0);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_out_data", out_data, 0);
    check_val("rst_err", err, 0);
    check_val("rst_enable", mm_enable, 0);
    check_val("rst_mm_A", mm_A, 0);
    check_val("rst_mm_B", mm_B, 0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);

    // A=1..9, B=9..1 against the known product
    for (int k = 0; k < 9; k++) begin
      ld_a[k] = 8'(k + 1);
      ld_b[k] = 8'(9 - k);
    end
    exp_w = '{30, 24, 18, 84, 69, 54, 138, 114, 90};
    words_to_bytes();
    run_compute(0, -1, 0, 0, 0);

    // all operands at maximum
    for (int k = 0; k < 9; k++) begin
      ld_a[k] = 8'd255;
      ld_b[k] = 8'd255;
      exp_w[k] = 195075;
    end
    words_to_bytes();
    run_compute(0, -1, 0, 0, 0);

    // identity A, backpressure after byte 4
    for (int k = 0; k < 9; k++) begin
      ld_a[k] = (k % 4 == 0) ? 8'd1 : 8'd0;
      ld_b[k] = 8'(k + 5);
    end
    model_words();
    words_to_bytes();
    run_compute(0, 4, 5, 0, 0);

    // done held low: timeout
    force_low = 1'b1;
    rand_operands();
    load_all(18, 0, 0);
    repeat (TMO) @(negedge clk);
    check_val("tmo_err_early", err, 0);
    check_val("tmo_busy_early", busy, 1);
    @(negedge clk);
    check_val("tmo_err", err, 1);
    check_val("tmo_in_ready", in_ready, 1);
    check_val("tmo_busy", busy, 0);
    force_low = 1'b0;

    // err is sticky and does not block
    rand_operands();
    model_words();
    words_to_bytes();
    run_compute(1, -1, 0, 1, 0);
    check_val("err_sticky", err, 1);

    // reset after 7 load bytes
    rand_operands();
    load_all(7, 0, 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    check_val("mid_rst_err", err, 0);
    check_val("mid_rst_mm_A", mm_A, 0);
    check_val("mid_rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);
    rand_operands();
    model_words();
    words_to_bytes();
    run_compute(0, -1, 0, 0, 0);

    // in_valid held high during WAIT/SEND, back to back
    for (int r = 0; r < 2; r++) begin
      rand_operands();
      model_words();
      words_to_bytes();
      run_compute(0, -1, 0, 1, 1);
    end

    // randomized traffic
    for (int r = 0; r < 20; r++) begin
      rand_operands();
      model_words();
      words_to_bytes();
      run_compute(1, int'($urandom_range(26)), int'($urandom_range(4)), 1, 1'($urandom_range(1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
